// File: rtl/if_id_pkg.sv
// Shared IF/ID definitions: default field widths, NOP encoding, the pipeline entry
// struct (also used by the ID/EX register) and the skid-buffer occupancy states.
package if_id_pkg;

    localparam int IF_ID_PC_W    = 16;
    localparam int IF_ID_INSTR_W = 16;

    localparam logic [IF_ID_INSTR_W-1:0] IF_ID_NOP = 16'h0000;

    typedef struct packed {
        logic [IF_ID_PC_W-1:0]    pc_plus_two;
        logic [IF_ID_INSTR_W-1:0] instruction;
    } if_id_entry_t;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } skid_state_t;

endpackage

// File: rtl/if_id_skid_buf.sv
// Two-entry IF/ID skid buffer with occupancy FSM (EMPTY/ONE/FULL); state changes on
// the falling clock edge and in_ready is registered so decode stalls never reach fetch combinationally.
module if_id_skid_buf
    import if_id_pkg::*;
#(
    parameter int                 PC_W      = IF_ID_PC_W,
    parameter int                 INSTR_W   = IF_ID_INSTR_W,
    parameter logic [INSTR_W-1:0] NOP_INSTR = {INSTR_W{1'b0}}
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    input  logic [PC_W-1:0]    in_pc,
    input  logic [INSTR_W-1:0] in_instr,
    input  logic               flush,
    input  logic               out_ready,
    output logic               in_ready,
    output logic               out_valid,
    output logic [PC_W-1:0]    out_pc,
    output logic [INSTR_W-1:0] out_instr
);

    skid_state_t        state_r, state_nxt_s;
    logic [PC_W-1:0]    head_pc_r, head_pc_nxt_s, tail_pc_r, tail_pc_nxt_s;
    logic [INSTR_W-1:0] head_ins_r, head_ins_nxt_s, tail_ins_r, tail_ins_nxt_s;
    logic               in_ready_r, out_valid_r;
    logic               accept_s, pop_s;

    assign accept_s = in_valid && in_ready_r;
    assign pop_s    = out_valid_r && out_ready;

    // Next occupancy and storage contents; an empty head always reads 0 / NOP.
    always_comb begin
        state_nxt_s    = state_r;
        head_pc_nxt_s  = head_pc_r;
        head_ins_nxt_s = head_ins_r;
        tail_pc_nxt_s  = tail_pc_r;
        tail_ins_nxt_s = tail_ins_r;
        if (flush) begin
            state_nxt_s    = ST_EMPTY;
            head_pc_nxt_s  = {PC_W{1'b0}};
            head_ins_nxt_s = NOP_INSTR;
        end else begin
            case (state_r)
                ST_EMPTY: begin
                    if (accept_s) begin
                        state_nxt_s    = ST_ONE;
                        head_pc_nxt_s  = in_pc;
                        head_ins_nxt_s = in_instr;
                    end else begin
                        state_nxt_s = ST_EMPTY;
                    end
                end
                ST_ONE: begin
                    if (accept_s && pop_s) begin
                        head_pc_nxt_s  = in_pc;
                        head_ins_nxt_s = in_instr;
                    end else if (accept_s) begin
                        state_nxt_s    = ST_FULL;
                        tail_pc_nxt_s  = in_pc;
                        tail_ins_nxt_s = in_instr;
                    end else if (pop_s) begin
                        state_nxt_s    = ST_EMPTY;
                        head_pc_nxt_s  = {PC_W{1'b0}};
                        head_ins_nxt_s = NOP_INSTR;
                    end else begin
                        state_nxt_s = ST_ONE;
                    end
                end
                ST_FULL: begin
                    if (pop_s) begin
                        state_nxt_s    = ST_ONE;
                        head_pc_nxt_s  = tail_pc_r;
                        head_ins_nxt_s = tail_ins_r;
                    end else begin
                        state_nxt_s = ST_FULL;
                    end
                end
                default: begin
                    state_nxt_s    = ST_EMPTY;
                    head_pc_nxt_s  = {PC_W{1'b0}};
                    head_ins_nxt_s = NOP_INSTR;
                end
            endcase
        end
    end

    // State, storage and registered handshake flags, updated on the falling edge.
    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_EMPTY;
            head_pc_r   <= {PC_W{1'b0}};
            head_ins_r  <= NOP_INSTR;
            tail_pc_r   <= {PC_W{1'b0}};
            tail_ins_r  <= NOP_INSTR;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            head_pc_r   <= head_pc_nxt_s;
            head_ins_r  <= head_ins_nxt_s;
            tail_pc_r   <= tail_pc_nxt_s;
            tail_ins_r  <= tail_ins_nxt_s;
            in_ready_r  <= (state_nxt_s != ST_FULL);
            out_valid_r <= (state_nxt_s != ST_EMPTY);
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign out_pc    = head_pc_r;
    assign out_instr = head_ins_r;

endmodule

// File: rtl/if_id_pipe_reg.sv
// IF/ID pipeline register with valid/ready handshake, flush and stall, clocked on negedge.
// IF_ID_SKID_EN selects the 2-entry skid buffer; otherwise a single entry with pass-through ready.
module if_id_pipe_reg
    import if_id_pkg::*;
#(
    parameter int                 PC_W      = IF_ID_PC_W,
    parameter int                 INSTR_W   = IF_ID_INSTR_W,
    parameter logic [INSTR_W-1:0] NOP_INSTR = {INSTR_W{1'b0}}
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [PC_W-1:0]    PC_plus_two,
    input  logic [INSTR_W-1:0] instruction,
    input  logic               flush,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [PC_W-1:0]    O_PC_plus_two,
    output logic [INSTR_W-1:0] O_instruction
);

`ifdef IF_ID_SKID_EN
    if_id_skid_buf #(
        .PC_W      (PC_W),
        .INSTR_W   (INSTR_W),
        .NOP_INSTR (NOP_INSTR)
    ) u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_pc     (PC_plus_two),
        .in_instr  (instruction),
        .flush     (flush),
        .out_ready (out_ready),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_pc    (O_PC_plus_two),
        .out_instr (O_instruction)
    );
`else
    logic               valid_r, valid_nxt_s;
    logic [PC_W-1:0]    pc_r, pc_nxt_s;
    logic [INSTR_W-1:0] ins_r, ins_nxt_s;
    logic               accept_s, pop_s;

    // A single slot can refill on the same edge it drains, hence ready passes through.
    assign in_ready = !valid_r || out_ready;
    assign accept_s = in_valid && in_ready;
    assign pop_s    = valid_r && out_ready;

    // Next contents of the single slot; flush wins over accept and pop.
    always_comb begin
        valid_nxt_s = valid_r;
        pc_nxt_s    = pc_r;
        ins_nxt_s   = ins_r;
        if (flush) begin
            valid_nxt_s = 1'b0;
            pc_nxt_s    = {PC_W{1'b0}};
            ins_nxt_s   = NOP_INSTR;
        end else if (accept_s) begin
            valid_nxt_s = 1'b1;
            pc_nxt_s    = PC_plus_two;
            ins_nxt_s   = instruction;
        end else if (pop_s) begin
            valid_nxt_s = 1'b0;
            pc_nxt_s    = {PC_W{1'b0}};
            ins_nxt_s   = NOP_INSTR;
        end else begin
            valid_nxt_s = valid_r;
        end
    end

    // Slot register, updated on the falling edge.
    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_r <= 1'b0;
            pc_r    <= {PC_W{1'b0}};
            ins_r   <= NOP_INSTR;
        end else begin
            valid_r <= valid_nxt_s;
            pc_r    <= pc_nxt_s;
            ins_r   <= ins_nxt_s;
        end
    end

    assign out_valid     = valid_r;
    assign O_PC_plus_two = pc_r;
    assign O_instruction = ins_r;
`endif

endmodule

// File: tb/tb_if_id_pipe_reg.sv
// Self-checking bench for if_id_pipe_reg: queue-based reference model compared every cycle,
// plus directed vectors with literal expectations. Follows IF_ID_SKID_EN like the RTL.
module tb_if_id_pipe_reg;

`ifdef IF_ID_SKID_EN
    localparam bit SK = 1'b1;
`else
    localparam bit SK = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready, flush, out_valid, out_ready;
    logic [15:0] PC_plus_two, instruction, O_PC_plus_two, O_instruction;

    int checks   = 0;
    int failures = 0;
    bit cmp_en   = 1'b0;

    logic [15:0] q_pc[$];
    logic [15:0] q_ins[$];
    bit          m_acc, m_pop;

    if_id_pipe_reg dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .PC_plus_two   (PC_plus_two),
        .instruction   (instruction),
        .flush         (flush),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .O_PC_plus_two (O_PC_plus_two),
        .O_instruction (O_instruction)
    );

    always #5 clk = ~clk;

    task automatic chk1(string nm, logic act, logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%b required=%b t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk16(string nm, logic [15:0] act, logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Model: a FIFO of capacity 2 (skid) or 1, observed through its head.
    function automatic logic m_valid();
        return q_pc.size() != 0;
    endfunction

    function automatic logic m_in_ready();
        if (SK) return q_pc.size() < 2;
        else    return (q_pc.size() == 0) || out_ready;
    endfunction

    function automatic logic [15:0] m_pc();
        return (q_pc.size() != 0) ? q_pc[0] : 16'h0000;
    endfunction

    function automatic logic [15:0] m_ins();
        return (q_ins.size() != 0) ? q_ins[0] : 16'h0000;
    endfunction

    always @(negedge clk) begin
        if (rst_n) begin
            m_acc = in_valid && m_in_ready();
            m_pop = m_valid() && out_ready;
            if (flush) begin
                q_pc.delete();
                q_ins.delete();
            end else begin
                if (m_pop) begin
                    void'(q_pc.pop_front());
                    void'(q_ins.pop_front());
                end
                if (m_acc) begin
                    q_pc.push_back(PC_plus_two);
                    q_ins.push_back(instruction);
                end
            end
        end
    end

    always @(negedge rst_n) begin
        q_pc.delete();
        q_ins.delete();
    end

    always @(posedge clk) begin
        #3;
        if (cmp_en) begin
            chk1 ("cmp_out_valid", out_valid,     m_valid());
            chk1 ("cmp_in_ready",  in_ready,      m_in_ready());
            chk16("cmp_pc",        O_PC_plus_two, m_pc());
            chk16("cmp_instr",     O_instruction, m_ins());
        end
    end

    task automatic cyc(bit iv, logic [15:0] pc, logic [15:0] ins, bit ordy, bit fl);
        @(posedge clk);
        #1;
        in_valid    = iv;
        PC_plus_two = pc;
        instruction = ins;
        out_ready   = ordy;
        flush       = fl;
    endtask

    task automatic lit(string nm, bit ev, bit er, logic [15:0] epc, logic [15:0] ein);
        #2;
        chk1 ({nm, "_valid"}, out_valid,     ev);
        chk1 ({nm, "_ready"}, in_ready,      er);
        chk16({nm, "_pc"},    O_PC_plus_two, epc);
        chk16({nm, "_instr"}, O_instruction, ein);
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; PC_plus_two = 16'h0; instruction = 16'h0;
        out_ready = 1'b0; flush = 1'b0;
        #2;
        chk1 ("rst_valid", out_valid, 1'b0);
        chk16("rst_instr", O_instruction, 16'h0000);
        chk16("rst_pc",    O_PC_plus_two, 16'h0000);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        cmp_en = 1'b1;
        #1 chk1("rst_rel_ready", in_ready, 1'b1);

        // streaming
        cyc(1'b1, 16'h0002, 16'h1234, 1'b1, 1'b0); lit("str0", 1'b0, 1'b1, 16'h0000, 16'h0000);
        cyc(1'b1, 16'h0004, 16'h5678, 1'b1, 1'b0); lit("str1", 1'b1, 1'b1, 16'h0002, 16'h1234);
        cyc(1'b1, 16'h0006, 16'h9ABC, 1'b1, 1'b0); lit("str2", 1'b1, 1'b1, 16'h0004, 16'h5678);
        cyc(1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0); lit("str3", 1'b1, 1'b1, 16'h0006, 16'h9ABC);
        cyc(1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0); lit("str4", 1'b0, 1'b1, 16'h0000, 16'h0000);

        // back-pressure: 0x2222 held on the input until taken
        cyc(1'b1, 16'h0010, 16'h1111, 1'b0, 1'b0); lit("bp0", 1'b0, 1'b1, 16'h0000, 16'h0000);
        cyc(1'b1, 16'h0012, 16'h2222, 1'b0, 1'b0); lit("bp1", 1'b1, SK,   16'h0010, 16'h1111);
        cyc(1'b1, 16'h0012, 16'h2222, 1'b0, 1'b0); lit("bp2", 1'b1, 1'b0, 16'h0010, 16'h1111);
        cyc(1'b1, 16'h0012, 16'h2222, 1'b1, 1'b0); lit("bp3", 1'b1, !SK,  16'h0010, 16'h1111);
        cyc(1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0); lit("bp4", 1'b1, 1'b1, 16'h0012, 16'h2222);
        cyc(1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0); lit("bp5", 1'b0, 1'b1, 16'h0000, 16'h0000);

        // simultaneous accept and pop with one entry held
        cyc(1'b1, 16'h0030, 16'h4444, 1'b0, 1'b0); lit("ap0", 1'b0, 1'b1, 16'h0000, 16'h0000);
        cyc(1'b1, 16'h0032, 16'h5555, 1'b1, 1'b0); lit("ap1", 1'b1, 1'b1, 16'h0030, 16'h4444);
        cyc(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0); lit("ap2", 1'b1, SK,   16'h0032, 16'h5555);
        cyc(1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0); lit("ap3", 1'b1, 1'b1, 16'h0032, 16'h5555);
        cyc(1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0); lit("ap4", 1'b0, 1'b1, 16'h0000, 16'h0000);

        // flush while full (skid) / holding one entry, with 0x3333 offered
        cyc(1'b1, 16'h0040, 16'hAAAA, 1'b0, 1'b0); lit("fl0", 1'b0, 1'b1, 16'h0000, 16'h0000);
        cyc(1'b1, 16'h0042, 16'hBBBB, 1'b0, 1'b0); lit("fl1", 1'b1, SK,   16'h0040, 16'hAAAA);
        cyc(1'b1, 16'h0044, 16'h3333, 1'b0, 1'b1); lit("fl2", 1'b1, 1'b0, 16'h0040, 16'hAAAA);
        cyc(1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0); lit("fl3", 1'b0, 1'b1, 16'h0000, 16'h0000);
        // flush beats an accept that the handshake would otherwise take
        cyc(1'b1, 16'h0050, 16'h6666, 1'b0, 1'b0); lit("fl4", 1'b0, 1'b1, 16'h0000, 16'h0000);
        cyc(1'b1, 16'h0052, 16'h3333, 1'b1, 1'b1); lit("fl5", 1'b1, 1'b1, 16'h0050, 16'h6666);
        cyc(1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0); lit("fl6", 1'b0, 1'b1, 16'h0000, 16'h0000);

        // flush while empty is a no-op
        cyc(1'b0, 16'h0000, 16'h0000, 1'b1, 1'b1); lit("fe0", 1'b0, 1'b1, 16'h0000, 16'h0000);
        cyc(1'b1, 16'h0060, 16'h7777, 1'b1, 1'b0); lit("fe1", 1'b0, 1'b1, 16'h0000, 16'h0000);
        cyc(1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0); lit("fe2", 1'b1, 1'b1, 16'h0060, 16'h7777);
        cyc(1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0); lit("fe3", 1'b0, 1'b1, 16'h0000, 16'h0000);

        // mixed traffic, checked by the model every cycle
        for (int i = 0; i < 300; i++) begin
            cyc(1'($urandom_range(0, 3) != 0), 16'($urandom), 16'($urandom),
                1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 15) == 0));
        end
        cyc(1'b0, 16'h0000, 16'h0000, 1'b1, 1'b1);

        // asynchronous reset with entries held
        cyc(1'b1, 16'h0070, 16'h8888, 1'b0, 1'b0);
        cyc(1'b1, 16'h0072, 16'h9999, 1'b0, 1'b0);
        cyc(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0);
        chk1("ar_held_valid", out_valid, 1'b1);
        rst_n = 1'b0;
        #1;
        chk1 ("ar_valid", out_valid, 1'b0);
        chk16("ar_instr", O_instruction, 16'h0000);
        chk16("ar_pc",    O_PC_plus_two, 16'h0000);
        @(posedge clk);
        #1 rst_n = 1'b1;
        #1 chk1("ar_rel_ready", in_ready, 1'b1);
        cyc(1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0); lit("ar_post", 1'b0, 1'b1, 16'h0000, 16'h0000);

        repeat (2) @(posedge clk);
        #4;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/if_id_pipe_reg.md
Name: if_id_pipe_reg

Overview:
Parametrised IF/ID pipeline register with elastic valid/ready handshake, flush (bubble insertion) and stall support.
- Sits between the fetch stage (PC+2 adder, instruction memory) and decode.
- Generalises the fixed 16-bit unconditional IF/ID latch to configurable widths.
- Adds an optional 2-entry skid buffer so decode back-pressure does not create a combinational ready path into fetch.

Parameters:
PC_W, 16, width of the PC_plus_two field
INSTR_W, 16, width of the instruction field
NOP_INSTR, {INSTR_W{1'b0}}, instruction value presented on O_instruction when no valid entry is held

Ports:
clk  input  1  stage clock; all state updates on the falling edge (negedge clk), as for the other pipeline registers
rst_n  input  1  asynchronous, active-low reset
in_valid  input  1  fetch presents a valid PC_plus_two/instruction pair
in_ready  output  1  block can accept a pair this cycle
PC_plus_two  input  PC_W  fetched PC+2
instruction  input  INSTR_W  fetched instruction word
flush  input  1  discard all held and incoming entries (taken branch/jump)
out_valid  output  1  O_* fields hold a valid entry
out_ready  input  1  decode consumes the head entry this cycle
O_PC_plus_two  output  PC_W  head entry PC+2
O_instruction  output  INSTR_W  head entry instruction, NOP_INSTR when out_valid=0

Behaviour:
- Reset (rst_n=0, asynchronous): count=0, out_valid=0, O_PC_plus_two=0, O_instruction=NOP_INSTR; in_ready reads 1 immediately after reset release.
- Transfer rules:
  - accept when in_valid && in_ready at the falling edge;
  - pop when out_valid && out_ready at the falling edge.
- Latency: an accepted pair appears on O_* one falling edge after acceptance when the block was empty.
- Skid mode: occupancy count in {0,1,2}, states EMPTY/ONE/FULL.
  - in_ready = (count != 2), driven from a register (no combinational dependence on out_ready).
  - out_valid = (count != 0). O_* = head entry; when count=0, O_* = 0 / NOP_INSTR.
  - EMPTY: accept -> ONE.
  - ONE: accept && pop -> ONE, new entry becomes head; accept only -> FULL; pop only -> EMPTY.
  - FULL: pop -> ONE, second entry becomes head; no accept possible.
  - FIFO order is strictly preserved; no entry is ever duplicated or dropped except by flush.
- Flush has priority over every other event. At the falling edge with flush=1:
  - count -> 0 and the incoming pair is ignored, even if in_valid && in_ready;
  - the pop, if any, still counts as consumed by decode;
  - O_instruction = NOP_INSTR from that edge onward.
- Flush while EMPTY is a no-op.
- Stall: out_ready=0 holds O_* stable with out_valid asserted; the block fills to FULL, then deasserts in_ready.
- Reset mid-operation discards all entries asynchronously.
- Width rule: fields are stored verbatim; no arithmetic is performed on the PC.

Optional Feature:
IF_ID_SKID_EN
- Defined: 2-entry skid buffer as above; in_ready is registered.
- Undefined: single entry; in_ready = !out_valid || out_ready (combinational pass-through of ready). Accept/pop/flush rules are unchanged, with count limited to {0,1}; the FULL state does not exist.

Decomposition:
- Shared package (if_id_pkg):
  - default PC_W/INSTR_W constants;
  - NOP encoding constant;
  - an if_id_entry_t struct typedef {pc_plus_two, instruction}, reused by the ID/EX register.
- One sub-module is natural: if_id_skid_buf, the 2-entry storage plus count FSM, instantiated only under IF_ID_SKID_EN.

Test Plan:
- Reset: hold rst_n=0 mid-cycle with entries held -> out_valid=0, O_instruction=0x0000, O_PC_plus_two=0 immediately (asynchronous); in_ready=1 after release.
- Streaming: out_ready=1, push PC_plus_two=0x0002/0x0004/0x0006 with instr 0x1234/0x5678/0x9ABC on consecutive edges -> each appears one falling edge later, in order, with no gaps.
- Back-pressure (skid): out_ready=0, push 0x1111 then 0x2222 -> FULL, in_ready=0, O_instruction stays 0x1111; raise out_ready -> 0x1111 then 0x2222 output, in_ready=1 after the first pop.
- Simultaneous accept+pop at count=1 -> count stays 1, head is replaced by the new word, no loss.
- Flush with FULL and in_valid=1 (instr 0x3333) -> next edge out_valid=0, O_instruction=NOP_INSTR, 0x3333 never appears.
- Macro off: same stimulus as back-pressure -> in_ready follows out_ready combinationally, at most one entry held, 0x2222 is accepted only on the edge where 0x1111 pops.
